// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_pkg
// Description : Shared types and helpers for the gate truth-table sweeper.
//               Holds the sweep FSM state encoding, the reference-function
//               mode encodings, and expected(), the golden reduction
//               function evaluated over the low n bits of a MAX_N-wide
//               vector.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_sweep_pkg;

    // Widest gate the sweeper supports; expected() takes vectors this wide.
    localparam int MAX_N = 8;

    // Reference functions selectable on the mode input. Codes 6 and 7 are
    // not listed and evaluate as NAND.
    localparam logic [2:0] MODE_NAND = 3'd0;
    localparam logic [2:0] MODE_AND  = 3'd1;
    localparam logic [2:0] MODE_OR   = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Reduction over bits [n-1:0] of vec. Bits at and above n are masked:
    // forced to 1 for the AND reduction and to 0 for OR/XOR, so they never
    // influence the result. For n=1 NAND/NOR both collapse to NOT.
    function automatic logic expected(
        input logic [2:0]       mode,
        input logic [MAX_N-1:0] vec,
        input int unsigned      n
    );
        logic [MAX_N:0]   w_full;
        logic [MAX_N-1:0] w_mask;
        logic             w_and;
        logic             w_or;
        logic             w_xor;
        logic             w_res;
        // 1 << n, then minus one in the low MAX_N bits gives n ones; for
        // n == MAX_N the low bits are zero and the subtraction wraps to '1.
        w_full = (MAX_N+1)'(1) << n;
        w_mask = w_full[MAX_N-1:0] - MAX_N'(1);
        w_and  = &(vec | ~w_mask);
        w_or   = |(vec & w_mask);
        w_xor  = ^(vec & w_mask);
        case (mode)
            MODE_AND:  w_res = w_and;
            MODE_OR:   w_res = w_or;
            MODE_NOR:  w_res = ~w_or;
            MODE_XOR:  w_res = w_xor;
            MODE_XNOR: w_res = ~w_xor;
            default:   w_res = ~w_and;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_sweep_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_checker_if
// Description : Bundle between the sweeper and the bench/board top level.
//               master : the side that requests sweeps and hosts the gate
//                        under test (drives start, mode, dut_x).
//               slave  : the sweeper itself (drives stimulus and results).
// Signals     : start, mode[2:0], dut_x          master -> slave
//               vec[N-1:0], busy, done, pass,
//               err_count[N:0], fail_valid,
//               fail_vec[N-1:0]                  slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_sweep_checker_if #(
    parameter int N = 2
);
    logic         start;
    logic [2:0]   mode;
    logic         dut_x;
    logic [N-1:0] vec;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
    logic         fail_valid;
    logic [N-1:0] fail_vec;

    modport master (
        output start, mode, dut_x,
        input  vec, busy, done, pass, err_count, fail_valid, fail_vec
    );

    modport slave (
        input  start, mode, dut_x,
        output vec, busy, done, pass, err_count, fail_valid, fail_vec
    );
endinterface
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : gate_ref_model
// Description : Combinational reference gate. Returns the expected output of
//               an N-input gate of the selected mode for the given vector.
// Ports       : i_mode[2:0]   reference function select
//               i_vec[N-1:0]  applied input vector
//               o_expected    expected gate output
// Revision    : 1.0 - initial release
// ============================================================================
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N = 2
) (
    input  wire logic [2:0]   i_mode,
    input  wire logic [N-1:0] i_vec,
    output logic              o_expected
);

    logic [MAX_N-1:0] w_vec_wide;

    // A zero-width replication is illegal, so the N == MAX_N case is split.
    generate
        if (N < MAX_N) begin : g_pad
            assign w_vec_wide = {{(MAX_N-N){1'b0}}, i_vec};
        end else begin : g_full
            assign w_vec_wide = i_vec[MAX_N-1:0];
        end
    endgenerate

    assign o_expected = expected(i_mode, w_vec_wide, N);

endmodule
`default_nettype wire

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_checker
// Description : Clocked truth-table sweeper for single-output N-input gates.
//               Drives every input vector, waits SETTLE_CYC cycles, compares
//               dut_x against the reference function and accumulates a
//               mismatch count plus the first failing vector.
// Parameters  : N          gate inputs (1..8)
//               SETTLE_CYC cycles between applying a vector and sampling
//                          (1..15)
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               bus        gate_sweep_checker_if.slave (start, mode, dut_x in;
//                          vec, busy, done, pass, err_count, fail_valid,
//                          fail_vec out, all registered)
// Options     : STOP_ON_FAIL_EN - when defined the sweep ends at the first
//               mismatch, leaving vec on the failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N          = 2,
    parameter int SETTLE_CYC = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    gate_sweep_checker_if.slave bus
);

    localparam int               c_cnt_w       = 4;
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYC - 1);
    localparam logic [N-1:0]     c_vec_last    = '1;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_mode, w_mode_nxt;
    logic [N-1:0]       r_vec, w_vec_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_pass, w_pass_nxt;
    logic [N:0]         r_err, w_err_nxt;
    logic               r_fail_valid, w_fail_valid_nxt;
    logic [N-1:0]       r_fail_vec, w_fail_vec_nxt;

    logic w_expected;
    logic w_mismatch;
    logic w_fail_stop;

    gate_ref_model #(
        .N (N)
    ) u_ref (
        .i_mode     (r_mode),
        .i_vec      (r_vec),
        .o_expected (w_expected)
    );

    assign w_mismatch = bus.dut_x ^ w_expected;

`ifdef STOP_ON_FAIL_EN
    assign w_fail_stop = w_mismatch;
`else
    assign w_fail_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_mode_nxt       = r_mode;
        w_vec_nxt        = r_vec;
        w_cnt_nxt        = r_cnt;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_pass_nxt       = r_pass;
        w_err_nxt        = r_err;
        w_fail_valid_nxt = r_fail_valid;
        w_fail_vec_nxt   = r_fail_vec;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_mode_nxt       = bus.mode;
                    w_vec_nxt        = '0;
                    w_err_nxt        = '0;
                    w_fail_valid_nxt = 1'b0;
                    w_pass_nxt       = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = ST_APPLY;
                end
            end

            ST_APPLY: begin
                w_cnt_nxt   = c_settle_load;
                w_state_nxt = ST_SETTLE;
            end

            // The counter is checked before decrementing, so a load of
            // SETTLE_CYC-1 yields exactly SETTLE_CYC cycles in this state.
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end

            ST_CHECK: begin
                if (w_mismatch) begin
                    w_err_nxt = r_err + (N+1)'(1);
                    if (!r_fail_valid) begin
                        w_fail_vec_nxt   = r_vec;
                        w_fail_valid_nxt = 1'b1;
                    end
                end
                if ((r_vec == c_vec_last) || w_fail_stop) begin
                    // done and pass are registered here so both are visible
                    // together during the DONE cycle.
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_pass_nxt  = (w_err_nxt == '0);
                    w_state_nxt = ST_DONE;
                end else begin
                    w_vec_nxt   = r_vec + N'(1);
                    w_state_nxt = ST_APPLY;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= MODE_NAND;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_vec        <= w_vec_nxt;
            r_cnt        <= w_cnt_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err        <= w_err_nxt;
            r_fail_valid <= w_fail_valid_nxt;
            r_fail_vec   <= w_fail_vec_nxt;
        end
    end

    assign bus.vec        = r_vec;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_vec   = r_fail_vec;

endmodule
`default_nettype wire
